div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencing controller for the EXE-stage integer divider. It accepts one div/mod request at a time from EXE, handles operand sign preparation, and steps an iterative unsigned divide core. It then applies sign and divide-by-zero correction and holds the result until EXE consumes it. It replaces the dual signed/unsigned divider IP instances with one shared, flushable, fixed-latency unit.

## Interface
Parameters:
- WIDTH, 32, operand/result width; CALC length = WIDTH cycles

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  EXE presents a div/mod op
- req_ready  out  1  controller can accept; = (state==IDLE) && !flush
- req_op  in  2  bit0 = unsigned, bit1 = mod; 00 div.w, 01 div.wu, 10 mod.w, 11 mod.wu
- req_src1  in  WIDTH  dividend (rj)
- req_src2  in  WIDTH  divisor (rk)
- flush  in  1  cancel any in-flight op
- resp_valid  out  1  result available; high only in DONE
- resp_ready  in  1  EXE consumes result
- resp_result  out  WIDTH  quotient or remainder per latched op
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: on req_valid && req_ready, latch op, src1, src2 → PREP. Inputs need not stay stable after accept.
- PREP (1 cycle): compute |src1| and |src2| for signed ops (raw values for unsigned), q_neg = signed && (src1[W-1]^src2[W-1]), r_neg = signed && src1[W-1], dz = (src2==0). Pulse start to the core → CALC.
- CALC (WIDTH cycles): core produces one quotient bit per cycle via restoring shift-subtract. Counter runs WIDTH-1 down to 0; count==0 → FIX.
- FIX (1 cycle): if dz: quotient = all-ones, remainder = raw src1. Else quotient = q_neg ? -q : q and remainder = r_neg ? -r : r (two's complement, truncated to WIDTH). Register the selected value into resp_result → DONE.
- Signed overflow (0x8000_0000 / -1) falls out naturally: quotient 0x8000_0000, remainder 0.
- DONE: resp_valid=1, resp_result held stable; on resp_ready → IDLE. No accept in the same cycle (req_ready only in IDLE).
- flush: from any state → IDLE at next edge, no response produced. Flush in DONE with resp_ready high counts as consumed; the result is the same either way. flush blocks accept in the same cycle.
- reset: from any state → IDLE; core counter and registers cleared.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_result 0, busy 0. req_ready 1 once reset deasserts (absent flush).
- Accept edge = cycle 0. PREP in cycle 1, CALC in cycles 2..WIDTH+1, FIX in cycle WIDTH+2. resp_valid rises in cycle WIDTH+3 (35 for WIDTH=32), fixed regardless of operands, including dz.
- Minimum issue interval: WIDTH+4 cycles (the DONE handshake cycle plus one IDLE cycle).
- resp_result changes only in the FIX→DONE transition and on reset.
- All outputs registered except req_ready and busy, which decode registered state; req_ready also includes flush.

## Structure
- Shared package div_pkg holds:
  - op encoding localparams DIV_W=2'b00, DIV_WU=2'b01, MOD_W=2'b10, MOD_WU=2'b11
  - the state encoding (IDLE..DONE)
- Sub-module div_iter_core (WIDTH param): unsigned restoring divider.
  - Ports: start, dividend, divisor, quotient, remainder, done.
  - Has its own iteration counter and a sync clear driven by reset|flush.
- div_ctrl owns the FSM, sign prep/fixup, dz override, and the response register.

## Test plan
- div.w 100 / -7 → 0xFFFF_FFF2. mod.w -100 % 7 → 0xFFFF_FFFE. resp_valid first high exactly 35 cycles after accept.
- div.wu 0xFFFF_FFFF / 2 → 0x7FFF_FFFF. mod.wu same operands → 0x0000_0001.
- div.w 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. mod.w same operands → 0.
- Divide by zero: div.wu 7 / 0 → 0xFFFF_FFFF. mod.w 0xFFFF_FFFB % 0 → 0xFFFF_FFFB. Latency still 35.
- Assert flush in CALC cycle 10 → resp_valid never rises and req_ready is high next cycle. Then issue div.w 9 / 3 → 3 after 35 cycles. Repeat with reset instead of flush → same recovery; all outputs return to reset values.
- Hold resp_ready low 5 cycles in DONE → resp_result stable, req_ready 0, busy 1. Raise resp_ready → IDLE next cycle; a req_valid held throughout is accepted one cycle after the handshake.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the EXE-stage divider: op encoding and controller states.
// Op bit0 selects unsigned, bit1 selects remainder instead of quotient.
// State encoding is shared so the controller and any debug/trace logic agree.
package div_pkg;

  localparam logic [1:0] DIV_W  = 2'b00;
  localparam logic [1:0] DIV_WU = 2'b01;
  localparam logic [1:0] MOD_W  = 2'b10;
  localparam logic [1:0] MOD_WU = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after start.
// Operands are captured on start; done is high during the final iteration cycle,
// so quotient/remainder are final on the cycle after done. clear aborts and zeroes.
module div_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             running;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;

  // Trial subtraction: shift the next dividend bit into the partial remainder.
  // Since rem < divisor, partial < 2^(WIDTH+1) and the sign of diff is exact.
  always_comb begin
    partial = {rem, quo[WIDTH-1]};
    diff    = partial - {1'b0, dvs};
  end

  // Iteration state: load on start, then one shift-subtract step per cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      quo     <= dividend;
      rem     <= '0;
      dvs     <= divisor;
      cnt     <= CW'(WIDTH - 1);
      running <= 1'b1;
    end else if (running) begin
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= partial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign done      = running && (cnt == '0);

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the shared EXE divider: sign prep, iterative core, sign/div-by-zero fixup.
// Fixed latency: resp_valid rises WIDTH+3 cycles after accept, independent of operands.
// One op in flight; result held in DONE until resp_ready; flush drops the op silently.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             busy
);

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] src1_q;
  logic [WIDTH-1:0] src2_q;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic             is_signed;
  logic             is_mod;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH-1:0] fix_result;

  logic             core_start;
  logic             core_clear;
  logic             core_done;
  logic [WIDTH-1:0] core_quo;
  logic [WIDTH-1:0] core_rem;

  assign req_ready = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);

  // Decode the latched op and form operand magnitudes for the unsigned core.
  // |0x8000_0000| stays 0x8000_0000, which is the correct unsigned magnitude.
  always_comb begin
    is_signed = (op_q == DIV_W) || (op_q == MOD_W);
    is_mod    = (op_q == MOD_W) || (op_q == MOD_WU);
    abs1      = (is_signed && src1_q[WIDTH-1]) ? (~src1_q + 1'b1) : src1_q;
    abs2      = (is_signed && src2_q[WIDTH-1]) ? (~src2_q + 1'b1) : src2_q;
  end

  // Final result selection: div-by-zero override, else sign-corrected core output.
  always_comb begin
    fix_result = '0;
    if (dz) begin
      fix_result = is_mod ? src1_q : '1;
    end else if (is_mod) begin
      fix_result = r_neg ? (~core_rem + 1'b1) : core_rem;
    end else begin
      fix_result = q_neg ? (~core_quo + 1'b1) : core_quo;
    end
  end

  assign core_start = (state == PREP);
  assign core_clear = reset || flush;

  div_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .clear     (core_clear),
    .start     (core_start),
    .dividend  (abs1),
    .divisor   (abs2),
    .quotient  (core_quo),
    .remainder (core_rem),
    .done      (core_done)
  );

  // Controller FSM with the request latch and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
            state  <= PREP;
          end
        end
        PREP: begin
          q_neg <= is_signed && (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
          r_neg <= is_signed && src1_q[WIDTH-1];
          dz    <= (src2_q == '0);
          state <= CALC;
        end
        CALC: begin
          if (core_done) begin
            state <= FIX;
          end
        end
        FIX: begin
          resp_result <= fix_result;
          resp_valid  <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed ops with hand-computed results and latency.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_src1;
  logic [W-1:0] req_src2;
  logic         flush;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_result;
  logic         busy;

  div_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  typedef struct {
    logic [W-1:0] res;
    longint       t;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   next_id  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pop expected on each response rise; result must be stable through DONE.
  initial begin
    logic         prev;
    logic [W-1:0] held;
    exp_t         e;
    longint       lat;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (resp_valid && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp_valid", 64'(resp_valid), 64'd0);
        end else begin
          e   = sb.pop_front();
          lat = ($time - e.t + 5) / 10;
          chk($sformatf("resp_result#%0d", e.id), 64'(resp_result), 64'(e.res));
          chk($sformatf("latency#%0d", e.id), 64'(lat), 64'd35);
        end
        held = resp_result;
      end else if (resp_valid && prev) begin
        chk("resp_result_stable", 64'(resp_result), 64'(held));
      end
      prev = resp_valid;
    end
  end

  // Present a request from a negedge; returns the accepting posedge time.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input bit track, output longint acc_t);
    bit   ok;
    exp_t e;
    ok        = 1'b0;
    acc_t     = 0;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc_t = $time;
      if (track) begin
        e.res = res;
        e.t   = acc_t;
        e.id  = next_id;
        next_id++;
        sb.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res);
    longint t;
    issue(op, a, b, res, 1'b1, t);
    wait_idle();
  endtask

  initial begin
    longint t;
    longint n;
    bit     seen;
    reset      = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_src1   = '0;
    req_src2   = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    run_op(DIV_W,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run_op(MOD_W,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE);
    run_op(MOD_W,  32'd100,        32'hFFFF_FFF9, 32'h0000_0002);
    run_op(DIV_WU, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF);
    run_op(MOD_WU, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001);
    run_op(DIV_W,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_op(MOD_W,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);
    run_op(DIV_WU, 32'd7,          32'd0,         32'hFFFF_FFFF);
    run_op(MOD_W,  32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);

    // Flush mid-CALC: no response, immediately ready again.
    issue(DIV_W, 32'd1000, 32'd3, '0, 1'b0, t);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_req_ready", 64'(req_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_resp_valid", 64'(resp_valid), 64'd0);
    repeat (40) @(negedge clk);
    run_op(DIV_W, 32'd9, 32'd3, 32'd3);

    // Reset mid-CALC: everything back to reset values.
    issue(MOD_WU, 32'd1000, 32'd7, '0, 1'b0, t);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_resp_result", 64'(resp_result), 64'd0);
    chk("rst2_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0);
    chk("rst2_req_ready", 64'(req_ready), 64'd1);
    repeat (40) @(negedge clk);
    run_op(DIV_W, 32'd9, 32'd3, 32'd3);

    // Backpressure in DONE with a waiting request.
    resp_ready = 1'b0;
    issue(DIV_WU, 32'd1000, 32'd10, 32'd100, 1'b1, t);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold_resp_seen", 64'(seen), 64'd1);
    req_op    = DIV_W;
    req_src1  = 32'd50;
    req_src2  = 32'd5;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_result", 64'(resp_result), 64'd100);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    n = $time;
    issue(DIV_W, 32'd50, 32'd5, 32'd10, 1'b1, t);
    chk("accept_after_handshake", 64'(t - n), 64'd15);
    wait_idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
